// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounces mode/up/down buttons and steps RUN -> SET_SEC -> SET_MIN -> SET_HOUR.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the adjust buttons.
module clock_set_ctrl #(
  parameter int          DEBOUNCE_N     = 1_000_000,
  parameter logic [31:0] IDLE_N         = 32'd3_000_000_000,
  parameter int          REPEAT_DELAY_N = 50_000_000,
  parameter int          REPEAT_RATE_N  = 20_000_000
) (
  input  logic       clk_100MHz,
  input  logic       rst_time,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       change_out,
  output logic [1:0] select_time,
  output logic       adj_up,
  output logic       adj_down,
  output logic       run_en
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  localparam int              DB_W      = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_N - 1);
  localparam logic [31:0]     IDLE_LAST = IDLE_N - 32'd1;

  if (DEBOUNCE_N < 1 || REPEAT_DELAY_N < 1 || REPEAT_RATE_N < 1 || IDLE_N < 32'd1) begin : g_bad_param
    $error("clock_set_ctrl: all cycle-count parameters must be at least 1");
  end

  // bit 0 = mode, bit 1 = up, bit 2 = down
  logic [2:0]      raw_s;
  logic [2:0]      sync1_r, sync2_r, level_r, level_d_r;
  logic [DB_W-1:0] db_cnt_r [3];
  logic [2:0]      ev_s;
  logic            mode_ev_s, up_ev_s, down_ev_s;

  state_t          state_r, state_nx;
  logic [31:0]     idle_cnt_r;
  logic            in_set_s, timeout_s, adj_ok_s, up_fire_s, down_fire_s;
  logic            rep_up_s, rep_dn_s;

  logic            change_nx, run_nx, adj_up_nx, adj_down_nx;
  logic [1:0]      select_nx;

  assign raw_s = {btn_down, btn_up, btn_mode};

  // Synchronize, then accept a new level only after DEBOUNCE_N consecutive differing samples
  always_ff @(posedge clk_100MHz) begin
    if (rst_time) begin
      sync1_r   <= 3'b000;
      sync2_r   <= 3'b000;
      level_r   <= 3'b000;
      level_d_r <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_r[i] <= {DB_W{1'b0}};
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          level_r[i]  <= sync2_r[i];
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
        end
      end
    end
  end

  assign ev_s      = level_r & ~level_d_r;
  assign mode_ev_s = ev_s[0];
  assign up_ev_s   = ev_s[1];
  assign down_ev_s = ev_s[2];

  assign in_set_s    = (state_r != RUN);
  assign timeout_s   = in_set_s && (idle_cnt_r == IDLE_LAST);
  // A mode step or timeout owns the cycle; simultaneous up+down cancel each other
  assign adj_ok_s    = in_set_s && !mode_ev_s && !timeout_s;
  assign up_fire_s   = adj_ok_s && up_ev_s && !down_ev_s;
  assign down_fire_s = adj_ok_s && down_ev_s && !up_ev_s;

`ifdef AUTO_REPEAT_EN
  logic        rep_act_r, rep_dir_r, rep_first_r;
  logic [31:0] rep_cnt_r;
  logic        rep_hold_s, rep_hit_s;

  assign rep_hold_s = rep_act_r && adj_ok_s && !up_ev_s && !down_ev_s &&
                      (rep_dir_r ? (level_r[2] && !level_r[1]) : (level_r[1] && !level_r[2]));
  assign rep_hit_s  = rep_hold_s &&
                      (rep_first_r ? (rep_cnt_r == 32'(REPEAT_DELAY_N - 1))
                                   : (rep_cnt_r == 32'(REPEAT_RATE_N - 1)));
  assign rep_up_s   = rep_hit_s && !rep_dir_r;
  assign rep_dn_s   = rep_hit_s && rep_dir_r;

  // Repeat timer: armed by an initial adjust pulse, dropped on release, state change or other button
  always_ff @(posedge clk_100MHz) begin
    if (rst_time) begin
      rep_act_r   <= 1'b0;
      rep_dir_r   <= 1'b0;
      rep_first_r <= 1'b0;
      rep_cnt_r   <= 32'd0;
    end else if (up_fire_s || down_fire_s) begin
      rep_act_r   <= 1'b1;
      rep_dir_r   <= down_fire_s;
      rep_first_r <= 1'b1;
      rep_cnt_r   <= 32'd0;
    end else if (!rep_hold_s) begin
      rep_act_r   <= 1'b0;
      rep_first_r <= 1'b0;
      rep_cnt_r   <= 32'd0;
    end else if (rep_hit_s) begin
      rep_first_r <= 1'b0;
      rep_cnt_r   <= 32'd0;
    end else begin
      rep_cnt_r   <= rep_cnt_r + 32'd1;
    end
  end
`else
  assign rep_up_s = 1'b0;
  assign rep_dn_s = 1'b0;
`endif

  // Idle timer: cleared by any activity and in RUN, never allowed to wrap
  always_ff @(posedge clk_100MHz) begin
    if (rst_time) begin
      idle_cnt_r <= 32'd0;
    end else if (!in_set_s || (|ev_s) || rep_up_s || rep_dn_s || timeout_s) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_100MHz) begin
    if (rst_time) begin
      state_r     <= RUN;
      change_out  <= 1'b0;
      select_time <= 2'd0;
      adj_up      <= 1'b0;
      adj_down    <= 1'b0;
      run_en      <= 1'b1;
    end else begin
      state_r     <= state_nx;
      change_out  <= change_nx;
      select_time <= select_nx;
      adj_up      <= adj_up_nx;
      adj_down    <= adj_down_nx;
      run_en      <= run_nx;
    end
  end

  // Next state: timeout wins over a coincident mode step
  always_comb begin
    state_nx = state_r;
    if (timeout_s) begin
      state_nx = RUN;
    end else if (mode_ev_s) begin
      case (state_r)
        RUN:      state_nx = SET_SEC;
        SET_SEC:  state_nx = SET_MIN;
        SET_MIN:  state_nx = SET_HOUR;
        SET_HOUR: state_nx = RUN;
        default:  state_nx = RUN;
      endcase
    end else begin
      state_nx = state_r;
    end
  end

  // Output decode from the next state so outputs land together with the state
  always_comb begin
    change_nx   = 1'b0;
    select_nx   = 2'd0;
    run_nx      = 1'b1;
    adj_up_nx   = up_fire_s || rep_up_s;
    adj_down_nx = down_fire_s || rep_dn_s;
    case (state_nx)
      RUN:      begin change_nx = 1'b0; select_nx = 2'd0; run_nx = 1'b1; end
      SET_SEC:  begin change_nx = 1'b1; select_nx = 2'd0; run_nx = 1'b0; end
      SET_MIN:  begin change_nx = 1'b1; select_nx = 2'd1; run_nx = 1'b1; end
      SET_HOUR: begin change_nx = 1'b1; select_nx = 2'd2; run_nx = 1'b1; end
      default:  begin change_nx = 1'b0; select_nx = 2'd0; run_nx = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: vector table for mode/adjust behaviour plus hand sequences
// for latency, idle timeout, reset interaction and (with AUTO_REPEAT_EN) auto-repeat timing.
module tb_clock_set_ctrl;

  localparam int DEB = 4;

  logic       clk_100MHz = 1'b0;
  logic       rst_time;
  logic       btn_mode, btn_up, btn_down;
  logic       change_out, adj_up, adj_down, run_en;
  logic [1:0] select_time;

  int checks = 0;
  int errors = 0;
  int both_hits = 0;

  clock_set_ctrl #(
    .DEBOUNCE_N(DEB),
    .IDLE_N(32'd100),
    .REPEAT_DELAY_N(20),
    .REPEAT_RATE_N(8)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_time(rst_time),
    .btn_mode(btn_mode),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .change_out(change_out),
    .select_time(select_time),
    .adj_up(adj_up),
    .adj_down(adj_down),
    .run_en(run_en)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    string      name;
    logic       m, u, d;
    int         cyc;
    logic       ch;
    logic [1:0] sel;
    logic       run;
    int         nup, ndn;
  } vec_t;

  vec_t vecs[$];
  int   n_up, n_dn;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance n edges, sampling 1 ns after each and counting adjust pulses
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_100MHz);
      #1;
      if (adj_up === 1'b1) n_up++;
      if (adj_down === 1'b1) n_dn++;
      if (adj_up === 1'b1 && adj_down === 1'b1) both_hits++;
    end
  endtask

  task automatic chk_outs(input string name, input logic ch, input logic [1:0] sel, input logic run);
    chk({name, ".change_out"}, int'(change_out), int'(ch));
    chk({name, ".select_time"}, int'(select_time), int'(sel));
    chk({name, ".run_en"}, int'(run_en), int'(run));
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; tick(10);
    btn_mode = 1'b0; tick(10);
  endtask

  int pulse_at[$];
  int exp_rep[$];

  initial begin
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    rst_time = 1'b1;
    n_up = 0; n_dn = 0;
    tick(3);
    rst_time = 1'b0;
    chk_outs("reset", 1'b0, 2'd0, 1'b1);
    chk("reset.adj_up", int'(adj_up), 0);
    chk("reset.adj_down", int'(adj_down), 0);

    vecs.push_back('{"idle50",    1'b0, 1'b0, 1'b0, 50, 1'b0, 2'd0, 1'b1, 0, 0});
    vecs.push_back('{"run_up",    1'b0, 1'b1, 1'b0, 10, 1'b0, 2'd0, 1'b1, 0, 0});
    vecs.push_back('{"run_rel",   1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd0, 1'b1, 0, 0});
    vecs.push_back('{"to_sec",    1'b1, 1'b0, 1'b0, 10, 1'b1, 2'd0, 1'b0, 0, 0});
    vecs.push_back('{"sec_rel",   1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd0, 1'b0, 0, 0});
    vecs.push_back('{"sec_up",    1'b0, 1'b1, 1'b0, 10, 1'b1, 2'd0, 1'b0, 1, 0});
    vecs.push_back('{"sec_urel",  1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd0, 1'b0, 0, 0});
    vecs.push_back('{"sec_dn",    1'b0, 1'b0, 1'b1, 10, 1'b1, 2'd0, 1'b0, 0, 1});
    vecs.push_back('{"sec_drel",  1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd0, 1'b0, 0, 0});
    vecs.push_back('{"to_min",    1'b1, 1'b0, 1'b0, 10, 1'b1, 2'd1, 1'b1, 0, 0});
    vecs.push_back('{"min_rel",   1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd1, 1'b1, 0, 0});
    vecs.push_back('{"min_glit",  1'b0, 1'b1, 1'b0, 3,  1'b1, 2'd1, 1'b1, 0, 0});
    vecs.push_back('{"min_gap",   1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd1, 1'b1, 0, 0});
    vecs.push_back('{"min_up",    1'b0, 1'b1, 1'b0, 10, 1'b1, 2'd1, 1'b1, 1, 0});
    vecs.push_back('{"min_urel",  1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd1, 1'b1, 0, 0});
    vecs.push_back('{"min_updn",  1'b0, 1'b1, 1'b1, 10, 1'b1, 2'd1, 1'b1, 0, 0});
    vecs.push_back('{"min_bothr", 1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd1, 1'b1, 0, 0});
    vecs.push_back('{"to_hour",   1'b1, 1'b0, 1'b0, 10, 1'b1, 2'd2, 1'b1, 0, 0});
    vecs.push_back('{"hour_rel",  1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd2, 1'b1, 0, 0});
    vecs.push_back('{"hour_up",   1'b0, 1'b1, 1'b0, 10, 1'b1, 2'd2, 1'b1, 1, 0});
    vecs.push_back('{"hour_urel", 1'b0, 1'b0, 1'b0, 10, 1'b1, 2'd2, 1'b1, 0, 0});
    vecs.push_back('{"to_run",    1'b1, 1'b0, 1'b0, 10, 1'b0, 2'd0, 1'b1, 0, 0});
    vecs.push_back('{"run_rel2",  1'b0, 1'b0, 1'b0, 10, 1'b0, 2'd0, 1'b1, 0, 0});

    foreach (vecs[i]) begin
      btn_mode = vecs[i].m; btn_up = vecs[i].u; btn_down = vecs[i].d;
      n_up = 0; n_dn = 0;
      tick(vecs[i].cyc);
      chk_outs(vecs[i].name, vecs[i].ch, vecs[i].sel, vecs[i].run);
      chk({vecs[i].name, ".n_up"}, n_up, vecs[i].nup);
      chk({vecs[i].name, ".n_dn"}, n_dn, vecs[i].ndn);
    end

    // exact mode latency: outputs switch on the DEB+3rd edge after the raw rise
    btn_mode = 1'b1;
    tick(DEB + 2);
    chk("lat.before", int'(change_out), 0);
    tick(1);
    chk_outs("lat.after", 1'b1, 2'd0, 1'b0);
    tick(3);
    btn_mode = 1'b0; tick(10);

    // mode and up together in SET_SEC: mode wins, no adjust pulse
    n_up = 0; n_dn = 0;
    btn_mode = 1'b1; btn_up = 1'b1; tick(10);
    btn_mode = 1'b0; btn_up = 1'b0; tick(10);
    chk_outs("mode_up", 1'b1, 2'd1, 1'b1);
    chk("mode_up.n_up", n_up, 0);

    // enter SET_HOUR and wait out the idle timer
    btn_mode = 1'b1; tick(DEB + 3);
    chk("idle.enter_sel", int'(select_time), 2);
    btn_mode = 1'b0;
    n_up = 0; n_dn = 0;
    tick(99);
    chk("idle.still_set", int'(change_out), 1);
    tick(1);
    chk_outs("idle.timeout", 1'b0, 2'd0, 1'b1);
    chk("idle.pulses", n_up + n_dn, 0);
    tick(10);

    // hold down for 60 cycles in SET_SEC and record pulse positions
    press_mode();
    chk("rep.in_sec", int'(select_time) + 4 * int'(change_out) + 8 * int'(run_en), 4);
`ifdef AUTO_REPEAT_EN
    exp_rep = '{7, 27, 35, 43, 51, 59};
`else
    exp_rep = '{7};
`endif
    btn_down = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick(1);
      if (adj_down === 1'b1) pulse_at.push_back(k);
      if (k == 60) btn_down = 1'b0;
    end
    chk("rep.count", pulse_at.size(), exp_rep.size());
    for (int j = 0; j < exp_rep.size() && j < pulse_at.size(); j++)
      chk($sformatf("rep.at%0d", j), pulse_at[j], exp_rep[j]);

    // reset mid-debounce discards the pending press
    rst_time = 1'b1; tick(1); rst_time = 1'b0;
    chk_outs("rst2", 1'b0, 2'd0, 1'b1);
    btn_mode = 1'b1; tick(3);
    rst_time = 1'b1; btn_mode = 1'b0; tick(1);
    rst_time = 1'b0; tick(20);
    chk_outs("rst_mid", 1'b0, 2'd0, 1'b1);

    // button held through reset gives exactly one event afterwards
    btn_mode = 1'b1; tick(2);
    rst_time = 1'b1; tick(2);
    rst_time = 1'b0;
    tick(DEB + 2);
    chk("held.before", int'(change_out), 0);
    tick(1);
    chk_outs("held.after", 1'b1, 2'd0, 1'b0);
    tick(20);
    chk_outs("held.once", 1'b1, 2'd0, 1'b0);
    btn_mode = 1'b0; tick(10);

    chk("never_both", both_hits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
